// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared genetic-algorithm pipeline constants and types
// Defaults shared by crossover_selector, crossover_engine and the mutation stage.
package ga_pkg;

    localparam int GA_GENE_W    = 4;
    localparam int GA_NUM_GENES = 8;
    localparam int GA_CHROM_W   = GA_GENE_W * GA_NUM_GENES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } xover_state_t;

endpackage

// File: rtl/crossover_engine.sv
// rtl/crossover_engine.sv - assembles two child chromosomes from latched parents and a select stream
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, abort       begin a crossover (IDLE only) / synchronous flush to IDLE
//   parent_a, parent_b parent chromosomes, latched on the start edge
//   select             per-gene select from crossover_selector (1: child0 takes A)
//   busy               high in MIX or DONE
//   out_valid/out_ready handshake for child0, child1, a_count
//   a_count            number of child0 genes taken from parent A
module crossover_engine
    import ga_pkg::*;
#(
    parameter int GENE_W    = GA_GENE_W,
    parameter int NUM_GENES = GA_NUM_GENES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [GENE_W*NUM_GENES-1:0]          parent_a,
    input  logic [GENE_W*NUM_GENES-1:0]          parent_b,
    input  logic                                 select,
    output logic                                 busy,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [GENE_W*NUM_GENES-1:0]          child0,
    output logic [GENE_W*NUM_GENES-1:0]          child1,
    output logic [$clog2(NUM_GENES+1)-1:0]       a_count
);

    localparam int CHROM_W = GENE_W * NUM_GENES;
    localparam int IDX_W   = $clog2(NUM_GENES);
    localparam int CNT_W   = $clog2(NUM_GENES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GENES - 1);

    xover_state_t       state;
    xover_state_t       state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [CHROM_W-1:0] pa_q;
    logic [CHROM_W-1:0] pb_q;
    logic [GENE_W-1:0]  gene_a;
    logic [GENE_W-1:0]  gene_b;

    assign gene_a = pa_q[idx*GENE_W +: GENE_W];
    assign gene_b = pb_q[idx*GENE_W +: GENE_W];

    // Both flags decode the state flop only, so no input reaches them combinationally.
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_MIX;
                ST_MIX:  if (idx == LAST_IDX) state_nxt = ST_DONE;
                ST_DONE: if (out_ready) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            a_count <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            child0  <= '0;
            child1  <= '0;
        end else if (abort) begin
            // Children keep whatever was partially assembled.
            idx     <= '0;
            a_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pa_q    <= parent_a;
                        pb_q    <= parent_b;
                        child0  <= '0;
                        child1  <= '0;
                        a_count <= '0;
                        idx     <= '0;
                    end
                end
                ST_MIX: begin
                    child0[idx*GENE_W +: GENE_W] <= select ? gene_a : gene_b;
                    child1[idx*GENE_W +: GENE_W] <= select ? gene_b : gene_a;
                    a_count <= a_count + {{(CNT_W-1){1'b0}}, select};
                    idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crossover_engine.sv
// tb/tb_crossover_engine.sv - directed table-driven bench for crossover_engine
module tb_crossover_engine;

    localparam int GENE_W    = 4;
    localparam int NUM_GENES = 8;
    localparam int CHROM_W   = GENE_W * NUM_GENES;
    localparam int CNT_W     = $clog2(NUM_GENES + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [CHROM_W-1:0] parent_a = '0;
    logic [CHROM_W-1:0] parent_b = '0;
    logic               select = 1'b0;
    logic               busy;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CHROM_W-1:0] child0;
    logic [CHROM_W-1:0] child1;
    logic [CNT_W-1:0]   a_count;

    int checks = 0;
    int errors = 0;

    crossover_engine #(.GENE_W(GENE_W), .NUM_GENES(NUM_GENES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .parent_a(parent_a), .parent_b(parent_b), .select(select),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .child0(child0), .child1(child1), .a_count(a_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CHROM_W-1:0] pa;
        logic [CHROM_W-1:0] pb;
        logic [7:0]         sel;      // bit i = select for gene i
        int                 hold;     // cycles out_ready stays low in DONE
        logic [CHROM_W-1:0] exp_c0;
        logic [CHROM_W-1:0] exp_c1;
        logic [CNT_W-1:0]   exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge, block in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        logic [CHROM_W-1:0] c0_hold;
        parent_a = v.pa;
        parent_b = v.pb;
        start    = 1'b1;
        step();                                  // start edge t
        start    = 1'b0;
        parent_a = ~v.pa;                        // latched copy must be used
        parent_b = ~v.pb;
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " valid_after_start"}, out_valid, 0);
        select = v.sel[0];
        for (int i = 1; i < NUM_GENES; i++) begin
            step();                              // edge t+i
            chk({tag, " valid_early"}, out_valid, 0);
            select = v.sel[i];
        end
        step();                                  // edge t+NUM_GENES
        select = 1'b0;
        chk({tag, " valid_at_latency"}, out_valid, 1);
        chk({tag, " child0"}, child0, v.exp_c0);
        chk({tag, " child1"}, child1, v.exp_c1);
        chk({tag, " a_count"}, a_count, v.exp_cnt);
        c0_hold = child0;
        for (int d = 0; d < v.hold; d++) begin
            step();
            chk({tag, " valid_held"}, out_valid, 1);
            chk({tag, " child0_stable"}, child0, c0_hold);
            chk({tag, " a_count_stable"}, a_count, v.exp_cnt);
        end
        out_ready = 1'b1;
        step();                                  // handshake edge
        out_ready = 1'b0;
        chk({tag, " valid_after_hs"}, out_valid, 0);
        chk({tag, " busy_after_hs"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{32'h76543210, 32'hFEDCBA98, 8'hFF, 0, 32'h76543210, 32'hFEDCBA98, 4'd8};
        vecs[1] = '{32'h76543210, 32'hFEDCBA98, 8'h55, 0, 32'hF6D4B290, 32'h7E5C3A18, 4'd4};
        vecs[2] = '{32'h76543210, 32'hFEDCBA98, 8'h00, 5, 32'hFEDCBA98, 32'h76543210, 4'd0};
        vecs[3] = '{32'h12345678, 32'h12345678, 8'hC3, 1, 32'h12345678, 32'h12345678, 4'd4};
        vecs[4] = '{32'hAAAAAAAA, 32'h55555555, 8'h0F, 0, 32'h5555AAAA, 32'hAAAA5555, 4'd4};

        // Reset state
        #12;
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst child0", child0, 0);
        chk("rst child1", child1, 0);
        chk("rst a_count", a_count, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
            step();
        end

        // start during MIX and during the handshake cycle is ignored
        parent_a = 32'h76543210;
        parent_b = 32'hFEDCBA98;
        start = 1'b1;
        step();
        start = 1'b0;
        select = 1'b1;
        for (int i = 1; i < NUM_GENES; i++) begin
            step();
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
        end
        step();
        chk("ign valid", out_valid, 1);
        chk("ign child0", child0, 32'h76543210);
        chk("ign a_count", a_count, 8);
        start = 1'b1;
        out_ready = 1'b1;
        step();                                  // handshake edge with start
        start = 1'b0;
        out_ready = 1'b0;
        chk("ign busy_after_hs", busy, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (busy || out_valid) seen++;
            end
            chk("ign no_second_result", seen, 0);
        end

        // abort at gene 3
        parent_a = 32'h76543210;
        parent_b = 32'hFEDCBA98;
        start = 1'b1;
        step();
        start = 1'b0;
        select = 1'b1;
        step(); step(); step();                  // genes 0..2
        chk("abort a_count_before", a_count, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        select = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort valid", out_valid, 0);
        chk("abort a_count", a_count, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (out_valid) seen++;
            end
            chk("abort valid_never", seen, 0);
        end
        run_vec(vecs[1], "post_abort");
        step();

        // asynchronous reset mid-MIX
        parent_a = 32'h76543210;
        parent_b = 32'hFEDCBA98;
        start = 1'b1;
        step();
        start = 1'b0;
        select = 1'b0;
        step(); step(); step();
        chk("arst child0_before", child0 != 0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst valid", out_valid, 0);
        chk("arst child0", child0, 0);
        chk("arst child1", child1, 0);
        chk("arst a_count", a_count, 0);
        @(negedge clk);
        rst = 1'b1;
        step(); step();
        chk("arst idle_after", busy, 0);
        run_vec(vecs[4], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
